// File: rtl/instmem_loader.sv
// instmem_loader: boot-time loader that turns a byte stream into sequential 32-bit instruction-memory writes.
// Define INSTMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module instmem_loader #(
    parameter int INSTRUCT_MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    localparam int MAX_WORDS = INSTRUCT_MEM_SIZE / 4;
    localparam int IDX_W     = $clog2(MAX_WORDS) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
`ifdef INSTMEM_LOADER_CHECKSUM_EN
        CSUM = 3'd4,
`endif
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

`ifdef INSTMEM_LOADER_CHECKSUM_EN
    localparam state_t PAYLOAD_END = CSUM;
`else
    localparam state_t PAYLOAD_END = DONE;
`endif

    state_t             state;
    state_t             state_next;
    logic [15:0]        count;
    logic [IDX_W-1:0]   word_idx;
    logic [1:0]         byte_cnt;
    logic [23:0]        assemble;
    logic [15:0]        len_in;
    logic               xfer;
    logic               launch;
    logic               last_word;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    assign last_word = ((32'(word_idx) + 32'd1) == 32'(count));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_hold   = 1'b1;
        launch     = 1'b0;
        len_in     = {byte_data, count[7:0]};

        case (state)
            LEN0, LEN1, DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`ifdef INSTMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERR: begin
                error = 1'b1;
            end
            default: ;
        endcase

        xfer = byte_valid & byte_ready;

        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    launch     = 1'b1;
                    state_next = LEN0;
                end
            end
            LEN0: begin
                if (xfer) state_next = LEN1;
            end
            LEN1: begin
                // The count is judged as soon as its high byte arrives, so an illegal
                // image never reaches the write port.
                if (xfer) begin
                    if (32'(len_in) > MAX_WORDS) begin
                        state_next = ERR;
                    end else if (len_in == 16'd0) begin
                        state_next = PAYLOAD_END;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer && byte_cnt == 2'd3 && last_word) state_next = PAYLOAD_END;
            end
`ifdef INSTMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer) state_next = (byte_data == csum) ? DONE : ERR;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            assemble <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (launch) begin
                count    <= '0;
                word_idx <= '0;
                byte_cnt <= '0;
                assemble <= '0;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end else if (xfer) begin
`ifdef INSTMEM_LOADER_CHECKSUM_EN
                csum <= csum ^ byte_data;
`endif
                case (state)
                    LEN0: count[7:0]  <= byte_data;
                    LEN1: count[15:8] <= byte_data;
                    DATA: begin
                        // Little-endian: each new byte enters at the top, so after three
                        // bytes the low 24 bits of the word sit in the assembler.
                        assemble <= {byte_data, assemble[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= {{(62 - IDX_W){1'b0}}, word_idx, 2'b00};
                            wr_data  <= {byte_data, assemble};
                            word_idx <= word_idx + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instmem_loader.sv
// Self-checking bench for instmem_loader: byte-list reference model, per-cycle compare, directed and random sessions.
module tb_instmem_loader;

    localparam int MEM = 1024;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    int vectors = 0;
    int miscompares = 0;

    instmem_loader #(.INSTRUCT_MEM_SIZE(MEM)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .error(error), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    // Reference model: session status derived from the list of bytes accepted so far.
    // mode: 0 idle, 1 session active, 2 loaded, 3 aborted
    int          mode = 0;
    logic [7:0]  acc[$];
    bit          m_wr = 1'b0;
    logic [95:0] m_cur = '0;
    logic [95:0] m_log[$];
    logic [95:0] dut_log[$];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int k;
        int n;
        logic [7:0] x;
        if (!reset_n) begin
            mode = 0;
            acc.delete();
            m_wr = 1'b0;
        end else begin
            m_wr = 1'b0;
            if (mode != 1) begin
                if (start) begin
                    mode = 1;
                    acc.delete();
                end
            end else if (byte_valid) begin
                acc.push_back(byte_data);
                k = acc.size();
                n = (k >= 2) ? int'({acc[1], acc[0]}) : 0;
                if (k == 2) begin
                    if (n > MEM / 4) mode = 3;
                    else if (n == 0 && !CSUM_EN) mode = 2;
                end else if (k > 2 && k <= 2 + 4 * n) begin
                    if ((k - 2) % 4 == 0) begin
                        m_wr  = 1'b1;
                        m_cur = {64'(4 * ((k - 2) / 4 - 1)),
                                 acc[k-1], acc[k-2], acc[k-3], acc[k-4]};
                        m_log.push_back(m_cur);
                    end
                    if (k == 2 + 4 * n && !CSUM_EN) mode = 2;
                end else if (k > 2) begin
                    x = 8'h00;
                    for (int i = 0; i < k - 1; i++) x = x ^ acc[i];
                    mode = (x == acc[k-1]) ? 2 : 3;
                end
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (!reset_n) begin
            chk("rst_byte_ready", byte_ready, 0);
            chk("rst_wr_en", wr_en, 0);
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_data", wr_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_error", error, 0);
            chk("rst_cpu_hold", cpu_hold, 1);
        end else begin
            chk("byte_ready", byte_ready, mode == 1);
            chk("wr_en", wr_en, m_wr);
            if (m_wr) begin
                chk("wr_addr", wr_addr, m_cur[95:32]);
                chk("wr_data", wr_data, m_cur[31:0]);
            end
            chk("busy", busy, mode == 1);
            chk("done", done, mode == 2);
            chk("error", error, mode == 3);
            chk("cpu_hold", cpu_hold, mode != 2);
            if (wr_en) dut_log.push_back({wr_addr, wr_data});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic byte_q_t with_csum(input byte_q_t b, input bit bad);
        byte_q_t r;
        logic [7:0] x;
        r = b;
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
        if (CSUM_EN) r.push_back(bad ? ~x : x);
        return r;
    endfunction

    // gap: 0 back-to-back, 1 idle cycle before every byte, 2 random idles
    task automatic send(input byte_q_t b, input int gap, input int start_at);
        start = 1'b1;
        byte_valid = 1'b0;
        cyc();
        start = 1'b0;
        foreach (b[i]) begin
            int idles;
            idles = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (idles) begin
                byte_valid = 1'b0;
                byte_data = 8'($urandom);
                cyc();
            end
            byte_valid = 1'b1;
            byte_data = b[i];
            start = (i == start_at);
            cyc();
            start = 1'b0;
        end
        byte_valid = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic clear_logs();
        dut_log.delete();
        m_log.delete();
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [95:0] exp);
        chk({nm, "_dut"}, (idx < dut_log.size()) ? dut_log[idx] : '1, exp);
        chk({nm, "_model"}, (idx < m_log.size()) ? m_log[idx] : '1, exp);
    endtask

    task automatic cmp_logs(input string nm);
        chk({nm, "_nwrites"}, 96'(dut_log.size()), 96'(m_log.size()));
        for (int i = 0; i < dut_log.size() && i < m_log.size(); i++)
            chk({nm, "_write"}, dut_log[i], m_log[i]);
    endtask

    task automatic chk_final(input string nm, input bit d, input bit e, input bit h);
        chk({nm, "_done"}, done, d);
        chk({nm, "_error"}, error, e);
        chk({nm, "_cpu_hold"}, cpu_hold, h);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_byte_ready"}, byte_ready, 0);
    endtask

    byte_q_t s;

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) cyc();
        chk("reset_cpu_hold", cpu_hold, 1);
        chk("reset_wr_addr", wr_addr, 0);
        reset_n = 1'b1;
        repeat (2) cyc();
        chk("idle_byte_ready", byte_ready, 0);

        // Two-word image, back-to-back and with alternate idle cycles, then with a stray start.
        for (int g = 0; g < 3; g++) begin
            clear_logs();
            s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
            send(with_csum(s, 1'b0), (g == 1) ? 1 : 0, (g == 2) ? 4 : -1);
            chk("two_word_nwrites", 96'(dut_log.size()), 2);
            chk_log("two_word_w0", 0, {64'h0, 32'h12345678});
            chk_log("two_word_w1", 1, {64'h4, 32'hDEADBEEF});
            chk_final("two_word", 1, 0, 0);
        end

        // Zero-length image.
        clear_logs();
        s = '{8'h00, 8'h00};
        send(with_csum(s, 1'b0), 0, -1);
        chk("zero_nwrites", 96'(dut_log.size()), 0);
        chk_final("zero", 1, 0, 0);

        // Illegal count 257 words.
        clear_logs();
        s = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send(s, 0, -1);
        chk("ovf_nwrites", 96'(dut_log.size()), 0);
        chk_final("ovf", 0, 1, 1);

        // Reset in the middle of a word, then a fresh one-word image.
        clear_logs();
        s = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        send(s, 0, -1);
        reset_n = 1'b0;
        cyc();
        chk("midrst_busy", busy, 0);
        chk("midrst_cpu_hold", cpu_hold, 1);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("midrst_nwrites", 96'(dut_log.size()), 0);
        s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send(with_csum(s, 1'b0), 0, -1);
        chk_log("after_rst_w0", 0, {64'h0, 32'hDDCCBBAA});
        chk_final("after_rst", 1, 0, 0);

        // Checksum byte handling (or its absence).
        clear_logs();
        s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send(s, 0, -1);
        chk_log("csum_w0", 0, {64'h0, 32'h04030201});
        chk_final("csum_ok", 1, 0, 0);
        clear_logs();
        s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        send(s, 0, -1);
        chk_log("csum2_w0", 0, {64'h0, 32'h04030201});
        chk_final("csum_last", !CSUM_EN, CSUM_EN, CSUM_EN);

        // Largest legal image: 256 words.
        clear_logs();
        s = '{8'h00, 8'h01};
        for (int i = 0; i < MEM; i++) s.push_back(8'($urandom));
        send(with_csum(s, 1'b0), 0, -1);
        chk("full_nwrites", 96'(dut_log.size()), MEM / 4);
        chk("full_last_addr", (dut_log.size() > 0) ? dut_log[dut_log.size()-1][95:32] : '1,
            MEM - 4);
        cmp_logs("full");
        chk_final("full", 1, 0, 0);

        // Randomized sessions.
        for (int t = 0; t < 40; t++) begin
            int n;
            clear_logs();
            s.delete();
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(257, 65535))
                                            : int'($urandom_range(0, 6));
            s.push_back(8'(n));
            s.push_back(8'(n >> 8));
            if (n <= MEM / 4) begin
                for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
                s = with_csum(s, $urandom_range(0, 3) == 0);
            end else begin
                for (int i = 0; i < 3; i++) s.push_back(8'($urandom));
            end
            send(s, $urandom_range(0, 2), ($urandom_range(0, 4) == 0) ? 3 : -1);
            cmp_logs("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instmem_loader.md
# instmem_loader

Boot-time writer for the processor's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles 32-bit little-endian words and writes them sequentially from byte address 0 into a writable instruction memory, the counterpart of the fetch-side read port. Holds the processor in reset until a complete, legal image has been written.

## Interface

- INSTRUCT_MEM_SIZE, 1024: instruction memory size in bytes; power of two, > 4.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session when idle.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  64  byte address, word-aligned (bits [1:0] = 0).
- wr_data  out  32  instruction word.
- busy  out  1  session in progress.
- done  out  1  image loaded successfully; sticky until next start.
- error  out  1  session aborted; sticky until next start.
- cpu_hold  out  1  keeps processor in reset while high.

## Operation

- Stream format: count_lo, count_hi (16-bit word count N, little-endian), then N words of 4 bytes each, least-significant byte first.
- States: IDLE, LEN0, LEN1, DATA, CSUM (only with macro), DONE, ERR.
- IDLE: byte_ready=0. start=1 -> LEN0, clears done/error/word index, sets busy and cpu_hold.
- LEN0 -> LEN1 on accepted byte; LEN1 -> on accepted byte:
  - N > INSTRUCT_MEM_SIZE/4 -> ERR.
  - N = 0 -> DONE (CSUM when macro defined).
  - else -> DATA.
- DATA: shift bytes into word assembler; 4th accepted byte completes word k. After the N-th word -> DONE (or CSUM).
- DONE: done=1, busy=0, cpu_hold=0. ERR: error=1, busy=0, cpu_hold=1.
- start in DONE or ERR begins a new session; start while busy is ignored.
- Byte transfer occurs only on clk edge with byte_valid & byte_ready; byte_ready=1 exactly in LEN0, LEN1, DATA, CSUM.
- No write is ever issued for a partial word or an illegal count.

## Timing

- Reset values: byte_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, error 0, cpu_hold 1, state IDLE.
- Reset asserted mid-session: immediate return to reset values; partially assembled word discarded.
- wr_en/wr_addr/wr_data are registered: asserted for one cycle, the cycle after the edge accepting word k's 4th byte; wr_addr = 4*k, k from 0.
- Back-to-back bytes: one byte per cycle, one word every 4 cycles; no bubbles inserted by loader.
- byte_valid gaps stall assembly with no effect on data or address.
- done/error/cpu_hold change the cycle after the edge accepting the final byte (or the illegal count_hi), coincident with the last wr_en.
- Word index width covers 0..INSTRUCT_MEM_SIZE/4; wr_addr upper bits zero.

## Configuration

- INSTMEM_LOADER_CHECKSUM_EN defined: one trailing byte follows the payload; it must equal XOR of all preceding bytes (count bytes included). Match -> DONE; mismatch -> ERR, cpu_hold stays 1 (words already written remain in memory). CSUM state present.
- Undefined: no trailing byte, no CSUM state; last data byte goes directly to DONE.

## Test plan

- start; bytes 02 00 78 56 34 12 EF BE AD DE back-to-back -> wr 0x12345678 @0, then 0xDEADBEEF @4 four cycles later; done=1, cpu_hold=0 next cycle.
- Same stream with byte_valid low on alternate cycles -> identical writes and final state; no extra wr_en.
- Count bytes 00 00 -> zero writes, done=1 (with macro: then byte 00 required).
- Count 01 01 (257 > 256) -> error=1, no wr_en, byte_ready=0, cpu_hold=1.
- reset_n low after 2 payload bytes -> all outputs at reset values, no write; fresh start with 01 00 AA BB CC DD -> 0xDDCCBBAA @0.
- Macro defined: 01 00 01 02 03 04 then 05 -> done; then 00 -> error=1, cpu_hold=1.
